// File: rtl/edf_irq_ser.sv
// edf_irq_ser: detects rising edges on the parallel interrupt lines, stamps each
// with an absolute deadline (time + per-line relative deadline) and serialises
// the pending requests round-robin onto a valid/ready push port.
module edf_irq_ser #(
    parameter  int          NrParIrqs = 2,
    parameter  int          TsWidth   = 16,
    parameter  int unsigned DefaultDl = 100,
    localparam int          IdWidth   = $clog2(NrParIrqs)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NrParIrqs-1:0] irq_i,
    input  logic                 cfg_we_i,
    input  logic [IdWidth-1:0]   cfg_id_i,
    input  logic [TsWidth-1:0]   cfg_dl_i,
    output logic                 push_valid_o,
    input  logic                 push_ready_i,
    output logic [IdWidth-1:0]   push_id_o,
    output logic [TsWidth-1:0]   push_dl_o,
    output logic [TsWidth-1:0]   time_o,
    output logic [NrParIrqs-1:0] drop_o
);

    typedef enum logic { IDLE, OFFER } state_e;

    state_e               state_q;
    logic [NrParIrqs-1:0] irq_q;
    logic [NrParIrqs-1:0] pending_q;
    logic [NrParIrqs-1:0] evt;
    logic [NrParIrqs-1:0] accept_vec;
    logic                 accept;
    logic [TsWidth-1:0]   abs_dl_q [NrParIrqs];
    logic [TsWidth-1:0]   rel_dl_q [NrParIrqs];
    logic [IdWidth-1:0]   rr_ptr_q;
    logic [IdWidth-1:0]   rr_next;
    logic [IdWidth-1:0]   sel_id;
    logic                 sel_found;
    int                   cand;

    // Free-running timestamp, wraps modulo 2^TsWidth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            time_o <= '0;
        end else begin
            time_o <= time_o + TsWidth'(1);
        end
    end

    // Rising-edge events and the one-hot view of the line being accepted now.
    always_comb begin
        evt        = irq_i & ~irq_q;
        accept     = push_valid_o & push_ready_i;
        accept_vec = '0;
        if (accept) begin
            accept_vec[push_id_o] = 1'b1;
        end
    end

    // Round-robin pointer moves just past the line that was accepted.
    always_comb begin
        if (int'(push_id_o) == NrParIrqs - 1) begin
            rr_next = '0;
        end else begin
            rr_next = push_id_o + IdWidth'(1);
        end
    end

    // First pending line at or after the round-robin pointer, cyclically.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = 0;
        for (int k = 0; k < NrParIrqs; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NrParIrqs) begin
                cand = cand - NrParIrqs;
            end
            if (!sel_found && pending_q[IdWidth'(cand)]) begin
                sel_found = 1'b1;
                sel_id    = IdWidth'(cand);
            end
        end
    end

    // Per-line capture: an event sets pending and stamps the deadline, unless the
    // line is already pending and not leaving this cycle, in which case it drops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q     <= '0;
            pending_q <= '0;
            drop_o    <= '0;
            for (int i = 0; i < NrParIrqs; i++) begin
                abs_dl_q[i] <= '0;
                rel_dl_q[i] <= TsWidth'(DefaultDl);
            end
        end else begin
            irq_q <= irq_i;
            for (int i = 0; i < NrParIrqs; i++) begin
                if (evt[i] && (!pending_q[i] || accept_vec[i])) begin
                    pending_q[i] <= 1'b1;
                    abs_dl_q[i]  <= time_o + rel_dl_q[i];
                end else if (evt[i]) begin
                    drop_o[i] <= 1'b1;
                end else if (accept_vec[i]) begin
                    pending_q[i] <= 1'b0;
                end
            end
            if (cfg_we_i && (int'(cfg_id_i) < NrParIrqs)) begin
                rel_dl_q[cfg_id_i] <= cfg_dl_i;
            end
        end
    end

    // Arbiter: pick a pending line in IDLE, hold the offer stable until accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            push_valid_o <= 1'b0;
            push_id_o    <= '0;
            push_dl_o    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        push_id_o    <= sel_id;
                        push_dl_o    <= abs_dl_q[sel_id];
                        push_valid_o <= 1'b1;
                        state_q      <= OFFER;
                    end
                end
                OFFER: begin
                    if (push_ready_i) begin
                        push_valid_o <= 1'b0;
                        rr_ptr_q     <= rr_next;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    push_valid_o <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edf_irq_ser.sv
// tb_edf_irq_ser: directed scenario tasks plus a randomized run against a
// behavioural reference model of the serialiser.
module tb_edf_irq_ser;

    localparam int N   = 2;
    localparam int DDL = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  irq;
    logic        cfg_we;
    logic [0:0]  cfg_id;
    logic [15:0] cfg_dl;
    logic        ready;
    logic        valid;
    logic [0:0]  push_id;
    logic [15:0] push_dl;
    logic [15:0] time_v;
    logic [1:0]  drop;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_time = '0;

    edf_irq_ser #(
        .NrParIrqs (N),
        .TsWidth   (16),
        .DefaultDl (DDL)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .irq_i        (irq),
        .cfg_we_i     (cfg_we),
        .cfg_id_i     (cfg_id),
        .cfg_dl_i     (cfg_dl),
        .push_valid_o (valid),
        .push_ready_i (ready),
        .push_id_o    (push_id),
        .push_dl_o    (push_dl),
        .time_o       (time_v),
        .drop_o       (drop)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock: track the expected time, then settle 1 time unit past the edge.
    task automatic tick;
        @(posedge clk);
        if (rst) exp_time = '0;
        else     exp_time = exp_time + 16'd1;
        #1;
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        irq    = 2'b00;
        ready  = 1'b0;
        cfg_we = 1'b0;
        cfg_id = 1'b0;
        cfg_dl = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid); end
        tests++; if (push_id !== 1'b0) begin fails++; $display("[TB] FAIL reset_id: got %0d expected 0", push_id); end
        tests++; if (push_dl !== 16'd0) begin fails++; $display("[TB] FAIL reset_dl: got %0d expected 0", push_dl); end
        tests++; if (time_v !== 16'd0) begin fails++; $display("[TB] FAIL reset_time: got %0d expected 0", time_v); end
        tests++; if (drop !== 2'b00) begin fails++; $display("[TB] FAIL reset_drop: got %b expected 00", drop); end
        tick();
        tests++; if (time_v !== 16'd1) begin fails++; $display("[TB] FAIL time_count: got %0d expected 1", time_v); end
        tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_valid: got %0b expected 0", valid); end
    endtask

    task automatic test_basic;
        do_reset();
        repeat (5) tick();
        tests++; if (time_v !== 16'd5) begin fails++; $display("[TB] FAIL basic_time: got %0d expected 5", time_v); end
        irq = 2'b01;
        tick();
        irq = 2'b00;
        tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_latency1: got %0b expected 0", valid); end
        tick();
        tests++; if (valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_valid: got %0b expected 1", valid); end
        tests++; if (push_id !== 1'b0) begin fails++; $display("[TB] FAIL basic_id: got %0d expected 0", push_id); end
        tests++; if (push_dl !== 16'd105) begin fails++; $display("[TB] FAIL basic_dl: got %0d expected 105", push_dl); end
        ready = 1'b1;
        tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_accept: got %0b expected 0", valid); end
        tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_pending_clear: got %0b expected 0", valid); end
        ready = 1'b0;
    endtask

    task automatic test_cfg_wrap;
        logic [15:0] t0;
        do_reset();
        cfg_we = 1'b1;
        cfg_id = 1'b1;
        cfg_dl = 16'hFFF0;
        tick();
        cfg_we = 1'b0;
        repeat (31) tick();
        irq = 2'b10;
        tick();
        irq = 2'b00;
        tick();
        tests++; if (valid !== 1'b1 || push_id !== 1'b1) begin fails++; $display("[TB] FAIL wrap_offer: got valid=%0b id=%0d expected valid=1 id=1", valid, push_id); end
        tests++; if (push_dl !== 16'h0010) begin fails++; $display("[TB] FAIL wrap_dl: got %h expected 0010", push_dl); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        // A config write coinciding with an event on that line uses the old value.
        cfg_we = 1'b1;
        cfg_id = 1'b0;
        cfg_dl = 16'd50;
        irq    = 2'b01;
        t0     = exp_time;
        tick();
        cfg_we = 1'b0;
        irq    = 2'b00;
        tick();
        tests++; if (push_dl !== t0 + 16'd100) begin fails++; $display("[TB] FAIL cfg_old_value: got %0d expected %0d", push_dl, t0 + 16'd100); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        irq   = 2'b01;
        t0    = exp_time;
        tick();
        irq = 2'b00;
        tick();
        tests++; if (valid !== 1'b1 || push_dl !== t0 + 16'd50) begin fails++; $display("[TB] FAIL cfg_new_value: got valid=%0b dl=%0d expected valid=1 dl=%0d", valid, push_dl, t0 + 16'd50); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [15:0] t0;
        logic [0:0]  exp_ids [6];
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            if (p == 2) begin
                // A single push of line 0 moves the pointer to 1 first.
                irq = 2'b01;
                tick();
                irq = 2'b00;
                tick();
                tests++; if (valid !== 1'b1 || push_id !== 1'b0) begin fails++; $display("[TB] FAIL rr_prime: got valid=%0b id=%0d expected valid=1 id=0", valid, push_id); end
                tick();
            end
            irq = 2'b11;
            t0  = exp_time;
            tick();
            irq = 2'b00;
            for (int j = 0; j < 2; j++) begin
                tick();
                tests++; if (valid !== 1'b1 || push_id !== exp_ids[2*p+j] || push_dl !== t0 + 16'd100) begin
                    fails++;
                    $display("[TB] FAIL b2b_push%0d_%0d: got valid=%0b id=%0d dl=%0d expected valid=1 id=%0d dl=%0d",
                             p, j, valid, push_id, push_dl, exp_ids[2*p+j], t0 + 16'd100);
                end
                tick();
                tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_bubble%0d_%0d: got %0b expected 0", p, j, valid); end
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_drop;
        logic [15:0] t0;
        do_reset();
        irq = 2'b01;
        t0  = exp_time;
        tick();
        irq = 2'b00;
        tick();
        tests++; if (valid !== 1'b1 || drop !== 2'b00) begin fails++; $display("[TB] FAIL drop_pre: got valid=%0b drop=%b expected valid=1 drop=00", valid, drop); end
        irq = 2'b01;
        tick();
        irq = 2'b00;
        tests++; if (drop !== 2'b01) begin fails++; $display("[TB] FAIL drop_flag: got %b expected 01", drop); end
        tests++; if (push_dl !== t0 + 16'd100) begin fails++; $display("[TB] FAIL drop_dl_kept: got %0d expected %0d", push_dl, t0 + 16'd100); end
        repeat (3) tick();
        tests++; if (valid !== 1'b1) begin fails++; $display("[TB] FAIL drop_hold: got %0b expected 1", valid); end
        ready = 1'b1;
        tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL drop_accept: got %0b expected 0", valid); end
        repeat (2) tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL drop_single_push: got %0b expected 0", valid); end
        tests++; if (drop !== 2'b01) begin fails++; $display("[TB] FAIL drop_sticky: got %b expected 01", drop); end
        ready = 1'b0;
    endtask

    task automatic test_accept_rerise;
        logic [15:0] t1;
        do_reset();
        irq = 2'b01;
        tick();
        irq = 2'b00;
        tick();
        ready = 1'b1;
        irq   = 2'b01;
        t1    = exp_time;
        tick();
        ready = 1'b0;
        irq   = 2'b00;
        tests++; if (valid !== 1'b0 || drop !== 2'b00) begin fails++; $display("[TB] FAIL rerise_accept: got valid=%0b drop=%b expected valid=0 drop=00", valid, drop); end
        tick();
        tests++; if (valid !== 1'b1 || push_id !== 1'b0 || push_dl !== t1 + 16'd100) begin
            fails++;
            $display("[TB] FAIL rerise_second: got valid=%0b id=%0d dl=%0d expected valid=1 id=0 dl=%0d", valid, push_id, push_dl, t1 + 16'd100);
        end
        tests++; if (drop !== 2'b00) begin fails++; $display("[TB] FAIL rerise_nodrop: got %b expected 00", drop); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_reset_mid_offer;
        do_reset();
        irq = 2'b10;
        tick();
        tick();
        tests++; if (valid !== 1'b1 || push_id !== 1'b1) begin fails++; $display("[TB] FAIL rmo_offer: got valid=%0b id=%0d expected valid=1 id=1", valid, push_id); end
        rst = 1'b1;
        tick();
        tests++; if (valid !== 1'b0 || push_id !== 1'b0 || push_dl !== 16'd0 || time_v !== 16'd0 || drop !== 2'b00) begin
            fails++;
            $display("[TB] FAIL rmo_reset: got valid=%0b id=%0d dl=%0d time=%0d drop=%b expected all zero", valid, push_id, push_dl, time_v, drop);
        end
        rst = 1'b0;
        tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL rmo_latency: got %0b expected 0", valid); end
        tick();
        tests++; if (valid !== 1'b1 || push_id !== 1'b1 || push_dl !== 16'd100) begin
            fails++;
            $display("[TB] FAIL rmo_reoffer: got valid=%0b id=%0d dl=%0d expected valid=1 id=1 dl=100", valid, push_id, push_dl);
        end
        irq   = 2'b00;
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    // Randomized traffic compared every cycle with a model built from the rules:
    // per-line request slots, sticky drops, and a cyclic scan for the next offer.
    task automatic test_random;
        logic [15:0] m_time, m_abs [2], m_rel [2], m_dl;
        logic [1:0]  m_pend, m_drop, m_prev;
        logic        m_valid, acc, ev, hit;
        int          m_id, m_rr, idx;
        do_reset();
        m_time = '0; m_pend = '0; m_drop = '0; m_prev = '0; m_valid = 1'b0;
        m_id = 0; m_rr = 0; m_dl = '0;
        for (int i = 0; i < N; i++) begin m_abs[i] = '0; m_rel[i] = 16'(DDL); end
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst    = ($urandom_range(0, 59) == 0);
            irq    = 2'($urandom_range(0, 3));
            ready  = ($urandom_range(0, 2) != 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_id = 1'($urandom_range(0, 1));
            cfg_dl = 16'($urandom);
            if (rst) begin
                m_time = '0; m_pend = '0; m_drop = '0; m_prev = '0; m_valid = 1'b0;
                m_id = 0; m_rr = 0; m_dl = '0;
                for (int i = 0; i < N; i++) begin m_abs[i] = '0; m_rel[i] = 16'(DDL); end
            end else begin
                acc = m_valid && ready;
                // The offer choice looks at requests as they stood before this edge.
                if (!m_valid) begin
                    for (int k = 0; k < N; k++) begin
                        idx = (m_rr + k) % N;
                        if (!m_valid && m_pend[idx]) begin
                            m_valid = 1'b1;
                            m_id    = idx;
                            m_dl    = m_abs[idx];
                        end
                    end
                end else if (acc) begin
                    m_valid = 1'b0;
                    m_rr    = (m_id + 1) % N;
                end
                for (int i = 0; i < N; i++) begin
                    ev  = irq[i] && !m_prev[i];
                    hit = acc && (m_id == i);
                    if (ev && (!m_pend[i] || hit)) begin
                        m_pend[i] = 1'b1;
                        m_abs[i]  = m_time + m_rel[i];
                    end else if (ev) begin
                        m_drop[i] = 1'b1;
                    end else if (hit) begin
                        m_pend[i] = 1'b0;
                    end
                end
                if (cfg_we && int'(cfg_id) < N) m_rel[cfg_id] = cfg_dl;
                m_prev = irq;
                m_time = m_time + 16'd1;
            end
            tick();
            tests++; if (valid !== m_valid) begin fails++; $display("[TB] FAIL rand_valid c%0d: got %0b expected %0b", cyc, valid, m_valid); end
            tests++; if (push_id !== 1'(m_id)) begin fails++; $display("[TB] FAIL rand_id c%0d: got %0d expected %0d", cyc, push_id, m_id); end
            tests++; if (push_dl !== m_dl) begin fails++; $display("[TB] FAIL rand_dl c%0d: got %0d expected %0d", cyc, push_dl, m_dl); end
            tests++; if (drop !== m_drop) begin fails++; $display("[TB] FAIL rand_drop c%0d: got %b expected %b", cyc, drop, m_drop); end
            tests++; if (time_v !== m_time) begin fails++; $display("[TB] FAIL rand_time c%0d: got %0d expected %0d", cyc, time_v, m_time); end
        end
        rst    = 1'b0;
        irq    = 2'b00;
        ready  = 1'b0;
        cfg_we = 1'b0;
    endtask

    // Scenario sequence and summary.
    initial begin
        rst    = 1'b1;
        irq    = 2'b00;
        ready  = 1'b0;
        cfg_we = 1'b0;
        cfg_id = 1'b0;
        cfg_dl = '0;
        test_reset();
        test_basic();
        test_cfg_wrap();
        test_back_to_back();
        test_drop();
        test_accept_rerise();
        test_reset_mid_offer();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
